// File: rtl/cfg_chain_loader.sv
// Loads a packed bitstream from a valid/ready word port and shifts it MSB-first into the segmented config chain.
// All outputs registered (start -> word_ready in 1 cycle); host stalls on word_ready low, loader stalls in LOAD up to TIMEOUT cycles.
module cfg_chain_loader #(
  parameter int NUM_SEGS = 2,
  parameter int SEG_BITS = 13,
  parameter int WORD_W   = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [WORD_W-1:0]                        word_in,
  input  logic                                     word_valid,
  output logic                                     word_ready,
  output logic                                     cfg_bit,
  output logic                                     cfg_shift_en,
  output logic [NUM_SEGS-1:0]                      seg_sel,
  output logic                                     prgm_b_out,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  output logic [$clog2(NUM_SEGS*SEG_BITS+1)-1:0]   bit_count
);

  localparam int TOTAL = NUM_SEGS * SEG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int SW    = $clog2(SEG_BITS + 1);
  localparam int BW    = $clog2(WORD_W + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(SEG_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BUF_FULL = BW'(WORD_W);
  localparam logic [BW-1:0] BUF_REST = BW'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT_SEG, DONE, ERROR} state_t;

  state_t state, next_state;

  logic [WORD_W-1:0]   wbuf, wbuf_n;
  logic [BW-1:0]       wbuf_cnt, wbuf_cnt_n;
  logic [SW-1:0]       seg_cnt, seg_cnt_n;
  logic [TW-1:0]       to_cnt, to_cnt_n;
  logic [CW-1:0]       bit_count_n;
  logic [NUM_SEGS-1:0] seg_sel_n;
  logic                word_ready_n, cfg_bit_n, cfg_shift_en_n;
  logic                prgm_b_n, busy_n, done_n, err_n;

  logic accept, has_bits, seg_end, last_bit, entry;

  assign accept   = word_ready & word_valid;
  assign has_bits = (wbuf_cnt != '0);
  assign last_bit = (state == SHIFT) && (bit_count == LAST_BIT);
  assign seg_end  = (state == SHIFT) && (seg_cnt == SEG_LAST);
  assign entry    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = LOAD;
      LOAD: begin
        if (abort)                  next_state = ERROR;
        else if (accept)            next_state = SHIFT;
        else if (to_cnt == TO_LAST) next_state = ERROR;
      end
      SHIFT: begin
        if (abort)                    next_state = ERROR;
        else if (last_bit)            next_state = DONE;
        else if (seg_end)             next_state = NEXT_SEG;
        else if (has_bits || accept)  next_state = SHIFT;
        else                          next_state = LOAD;
      end
      NEXT_SEG: begin
        if (abort)         next_state = ERROR;
        else if (has_bits) next_state = SHIFT;
        else               next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle values for the datapath and the registered outputs.
  always_comb begin
    wbuf_n      = wbuf;
    wbuf_cnt_n  = wbuf_cnt;
    seg_cnt_n   = seg_cnt;
    bit_count_n = bit_count;
    to_cnt_n    = '0;
    seg_sel_n   = seg_sel;
    done_n      = done;
    err_n       = err;
    cfg_bit_n   = 1'b0;

    // The chain shifts on every SHIFT cycle, including one cut short by abort.
    if (state == SHIFT) begin
      bit_count_n = bit_count + 1'b1;
      seg_cnt_n   = seg_end ? '0 : seg_cnt + 1'b1;
    end
    if ((state == LOAD) && !accept) to_cnt_n = to_cnt + 1'b1;
    if (state == NEXT_SEG)          seg_sel_n = seg_sel << 1;

    if (entry) begin
      bit_count_n = '0;
      seg_cnt_n   = '0;
      wbuf_cnt_n  = '0;
      seg_sel_n   = NUM_SEGS'(1);
      done_n      = 1'b0;
      err_n       = 1'b0;
    end

    case (next_state)
      SHIFT: begin
        if (has_bits) begin
          cfg_bit_n  = wbuf[WORD_W-1];
          wbuf_n     = wbuf << 1;
          wbuf_cnt_n = wbuf_cnt - 1'b1;
        end else begin
          cfg_bit_n  = word_in[WORD_W-1];
          wbuf_n     = word_in << 1;
          wbuf_cnt_n = BUF_REST;
        end
      end
      // A word accepted on the segment's last bit is parked across the boundary.
      NEXT_SEG: begin
        if (accept) begin
          wbuf_n     = word_in;
          wbuf_cnt_n = BUF_FULL;
        end
      end
      DONE: begin
        done_n     = 1'b1;
        seg_sel_n  = '0;
        wbuf_cnt_n = '0;
      end
      ERROR: begin
        err_n      = 1'b1;
        seg_sel_n  = '0;
        wbuf_cnt_n = '0;
      end
      default: ;
    endcase

    cfg_shift_en_n = (next_state == SHIFT);
    busy_n         = (next_state == LOAD) || (next_state == SHIFT) || (next_state == NEXT_SEG);
    prgm_b_n       = !busy_n;
    // Ask for the next word while the last buffered bit shifts, unless the load ends on that bit.
    word_ready_n   = (next_state == LOAD) ||
                     ((next_state == SHIFT) && (wbuf_cnt_n == '0) && (bit_count_n != LAST_BIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf         <= '0;
      wbuf_cnt     <= '0;
      seg_cnt      <= '0;
      to_cnt       <= '0;
      bit_count    <= '0;
      seg_sel      <= '0;
      word_ready   <= 1'b0;
      cfg_bit      <= 1'b0;
      cfg_shift_en <= 1'b0;
      prgm_b_out   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      wbuf         <= wbuf_n;
      wbuf_cnt     <= wbuf_cnt_n;
      seg_cnt      <= seg_cnt_n;
      to_cnt       <= to_cnt_n;
      bit_count    <= bit_count_n;
      seg_sel      <= seg_sel_n;
      word_ready   <= word_ready_n;
      cfg_bit      <= cfg_bit_n;
      cfg_shift_en <= cfg_shift_en_n;
      prgm_b_out   <= prgm_b_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
    end
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequencer that programs the configuration shift chain of the logic groups.
- Accepts a packed bitstream word-by-word from the host/configuration port over a valid/ready handshake.
- Serializes the bitstream MSB-first onto the chain and steps a one-hot program enable through the chain segments.
- Drives the active-low program indicator and reports done, error and progress.

Parameters:
- NUM_SEGS, 2, number of chain segments (logic groups) programmed in order 0..NUM_SEGS-1.
- SEG_BITS, 13, configuration bits per segment.
- WORD_W, 8, width of host bitstream words.
- TIMEOUT, 15, maximum consecutive cycles a needed word may be absent before error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load, sampled only in IDLE/DONE/ERROR.
- abort  in  1  terminates an active load.
- word_in  in  WORD_W  bitstream word, bit WORD_W-1 shifted first.
- word_valid  in  1  word_in valid.
- word_ready  out  1  loader accepts word_in this cycle.
- cfg_bit  out  1  serial configuration data to chain head.
- cfg_shift_en  out  1  chain shifts cfg_bit in on a rising edge where this is high.
- seg_sel  out  NUM_SEGS  one-hot enable of the segment being programmed; zero otherwise.
- prgm_b_out  out  1  active-low; 0 throughout an active load.
- busy  out  1  load in progress.
- done  out  1  sticky; all NUM_SEGS*SEG_BITS bits shifted.
- err  out  1  sticky; timeout or abort.
- bit_count  out  clog2(NUM_SEGS*SEG_BITS+1)  bits shifted in current load.

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0 except prgm_b_out=1. The word buffer is emptied and all counters are cleared.
- States: IDLE, LOAD, SHIFT, NEXT_SEG, DONE, ERROR.
- Start handling:
  - start in IDLE/DONE/ERROR -> LOAD next cycle.
  - On entry: done and err clear, bit_count=0, seg_sel=1 (segment 0), prgm_b_out=0, busy=1.
  - start while busy is ignored.
- LOAD:
  - word_ready=1.
  - Accept on word_valid&&word_ready: capture word into the buffer, go to SHIFT next cycle.
- SHIFT:
  - Each cycle: cfg_shift_en=1 and cfg_bit = next buffered bit, MSB-first; bit_count increments on that edge.
  - word_ready=1 during the cycle the last buffered bit is shifted, so back-to-back words give no bubble.
  - If that cycle has no accepted word and more bits are needed -> LOAD, with cfg_shift_en=0 while waiting.
- Segment boundary:
  - After the SEG_BITS-th bit of a segment (not the last segment) -> NEXT_SEG for exactly one cycle.
  - In NEXT_SEG: cfg_shift_en=0, word_ready=0, and seg_sel shifts left one place on exit.
  - The remaining bits of the buffered word carry over into the next segment.
- Completion:
  - After bit NUM_SEGS*SEG_BITS -> DONE.
  - On DONE: done=1, busy=0, seg_sel=0, prgm_b_out=1.
  - Unused trailing bits of the final word are discarded.
  - Total words consumed = ceil(NUM_SEGS*SEG_BITS/WORD_W).
- Timeout:
  - Counts consecutive LOAD cycles without accept. Reaching TIMEOUT -> ERROR.
  - On ERROR: err=1, busy=0, seg_sel=0, prgm_b_out=1, cfg_shift_en=0.
  - bit_count holds its value.
- abort in LOAD/SHIFT/NEXT_SEG -> ERROR next cycle. abort has priority over a same-cycle word accept and over a same-cycle final bit.
- word_ready=0 in IDLE, DONE, ERROR and NEXT_SEG.
- All outputs are registered. cfg_bit, cfg_shift_en and seg_sel change together.
- Reset mid-load returns to the reset state immediately; the chain content is undefined.

Test Plan:
- Defaults. start at cycle 0, host presents words 0xA5, 0x3C, 0xF0, 0x80 continuously, each accepted immediately.
  - Required timing: word_ready cycle 1; shifts cycles 2-14 with seg_sel=01; NEXT_SEG cycle 15; shifts cycles 16-28 with seg_sel=10; done=1 from cycle 29.
  - Required data: bit stream 10100101 00111100 11110000 10; 4 words consumed; bit_count=26.
- Host delays the 2nd word by 5 cycles.
  - cfg_shift_en is low for those 5 cycles.
  - Final shifted stream is identical to scenario 1; done=1; err=0.
- Host withholds the 3rd word.
  - After 15 LOAD cycles: err=1, busy=0, prgm_b_out=1, bit_count=16, seg_sel=00.
- abort at bit_count=20.
  - ERROR next cycle; no further cfg_shift_en pulses.
  - A following start with full data clears err and completes with done=1.
- reset asserted mid-SHIFT (between clock edges).
  - Outputs clear immediately: prgm_b_out=1, busy=0.
- start pulsed during SHIFT is ignored; done asserted later.
  - A second start in DONE reloads and clears done on entry.
